// File: rtl/ahb_slave_mux_hold.sv
// ahb_slave_mux_hold
// Slave-side AHB multiplexer, one instance per slave. Routes the address-phase
// payload of the granted master to the slave, freezes that selection while the
// slave inserts wait states, tracks the data-phase owner for write-data routing
// and response demux, and flags illegal (multi-hot) grants.
//
// Ports:
//   HCLK, HRESETn  clock and asynchronous active-low reset
//   payload_in     CHANNEL_NUM packed address-phase payloads (channel i at i*PAYLOAD)
//   sel            one-hot grant from the arbiter, all-zero means no grant
//   hwdata_in      CHANNEL_NUM packed write-data words (channel i at i*DATA_W)
//   hready         HREADYOUT of the attached slave
//   err_clr        synchronous clear of sel_err and viol_cnt
//   payload_out    selected address-phase payload
//   hwdata_out     write data of the current data-phase owner
//   dphase_sel     one-hot data-phase owner
//   addr_sel       effective address-phase select after hold and legality check
//   sel_err        sticky multi-hot grant flag
//   viol_cnt       saturating count of grant changes while the address is held
module ahb_slave_mux_hold #(
  parameter int CHANNEL_NUM = 4,
  parameter int PAYLOAD     = 34,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [CHANNEL_NUM*PAYLOAD-1:0] payload_in,
  input  logic [CHANNEL_NUM-1:0]         sel,
  input  logic [CHANNEL_NUM*DATA_W-1:0]  hwdata_in,
  input  logic                          hready,
  input  logic                          err_clr,
  output logic [PAYLOAD-1:0]             payload_out,
  output logic [DATA_W-1:0]              hwdata_out,
  output logic [CHANNEL_NUM-1:0]         dphase_sel,
  output logic [CHANNEL_NUM-1:0]         addr_sel,
  output logic                          sel_err,
  output logic [CNT_W-1:0]               viol_cnt
);

  localparam logic [CHANNEL_NUM-1:0] SEL_ONE = CHANNEL_NUM'(1);
  localparam logic [CNT_W-1:0]       CNT_MAX = '1;
  localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);

  logic [CHANNEL_NUM-1:0] held_sel;
  logic                   hold_active;
  logic [CHANNEL_NUM-1:0] sel_eff;
  logic                   multi_hot;
  logic                   grant_moved;

  // While the slave stalls, the captured grant overrides the live one so the
  // slave sees a stable address even if the arbiter re-grants. A grant with
  // two or more bits set is suppressed entirely rather than OR-ing payloads.
  always_comb begin
    sel_eff     = hold_active ? held_sel : sel;
    multi_hot   = (sel_eff & (sel_eff - SEL_ONE)) != '0;
    addr_sel    = multi_hot ? '0 : sel_eff;
    grant_moved = hold_active && (sel != held_sel);
  end

  // addr_sel is at most one-hot, so an AND-OR mux is sufficient.
  always_comb begin
    payload_out = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (addr_sel[i]) begin
        payload_out = payload_out | payload_in[i*PAYLOAD +: PAYLOAD];
      end
    end
  end

  always_comb begin
    hwdata_out = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (dphase_sel[i]) begin
        hwdata_out = hwdata_out | hwdata_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Each stalled edge re-captures the effective select, which is the held
  // select itself once the hold is active, so the held grant stays frozen.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      held_sel    <= '0;
      hold_active <= 1'b0;
    end else if (!hready) begin
      held_sel    <= sel_eff;
      hold_active <= 1'b1;
    end else begin
      hold_active <= 1'b0;
    end
  end

  // The address phase accepted at a ready edge becomes the data-phase owner.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dphase_sel <= '0;
    end else if (hready) begin
      dphase_sel <= addr_sel;
    end
  end

  // err_clr takes priority over any error event on the same edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_err  <= 1'b0;
      viol_cnt <= '0;
    end else if (err_clr) begin
      sel_err  <= 1'b0;
      viol_cnt <= '0;
    end else begin
      if (multi_hot) begin
        sel_err <= 1'b1;
      end
      if (grant_moved && (viol_cnt != CNT_MAX)) begin
        viol_cnt <= viol_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mux_hold.sv
// tb_ahb_slave_mux_hold
// Directed bench for ahb_slave_mux_hold. Instance a uses the default sizing;
// instance b uses 16 channels with a 2-bit violation counter to reach the
// top channel and counter saturation.
module tb_ahb_slave_mux_hold;

  localparam int A_CH = 4;
  localparam int B_CH = 16;
  localparam int PW   = 34;
  localparam int DW   = 32;

  logic clk;
  logic rst_n;

  logic [A_CH*PW-1:0] a_payload_in;
  logic [A_CH-1:0]    a_sel;
  logic [A_CH*DW-1:0] a_hwdata_in;
  logic               a_hready;
  logic               a_err_clr;
  logic [PW-1:0]      a_payload_out;
  logic [DW-1:0]      a_hwdata_out;
  logic [A_CH-1:0]    a_dphase_sel;
  logic [A_CH-1:0]    a_addr_sel;
  logic               a_sel_err;
  logic [7:0]         a_viol_cnt;

  logic [B_CH*PW-1:0] b_payload_in;
  logic [B_CH-1:0]    b_sel;
  logic [B_CH*DW-1:0] b_hwdata_in;
  logic               b_hready;
  logic               b_err_clr;
  logic [PW-1:0]      b_payload_out;
  logic [DW-1:0]      b_hwdata_out;
  logic [B_CH-1:0]    b_dphase_sel;
  logic [B_CH-1:0]    b_addr_sel;
  logic               b_sel_err;
  logic [1:0]         b_viol_cnt;

  int checkCount;
  int failCount;

  ahb_slave_mux_hold #(.CHANNEL_NUM(A_CH), .PAYLOAD(PW), .DATA_W(DW), .CNT_W(8)) dut_a (
    .HCLK(clk), .HRESETn(rst_n),
    .payload_in(a_payload_in), .sel(a_sel), .hwdata_in(a_hwdata_in),
    .hready(a_hready), .err_clr(a_err_clr),
    .payload_out(a_payload_out), .hwdata_out(a_hwdata_out),
    .dphase_sel(a_dphase_sel), .addr_sel(a_addr_sel),
    .sel_err(a_sel_err), .viol_cnt(a_viol_cnt)
  );

  ahb_slave_mux_hold #(.CHANNEL_NUM(B_CH), .PAYLOAD(PW), .DATA_W(DW), .CNT_W(2)) dut_b (
    .HCLK(clk), .HRESETn(rst_n),
    .payload_in(b_payload_in), .sel(b_sel), .hwdata_in(b_hwdata_in),
    .hready(b_hready), .err_clr(b_err_clr),
    .payload_out(b_payload_out), .hwdata_out(b_hwdata_out),
    .dphase_sel(b_dphase_sel), .addr_sel(b_addr_sel),
    .sel_err(b_sel_err), .viol_cnt(b_viol_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [A_CH-1:0] sel, input logic hready, input logic err_clr);
    a_sel     = sel;
    a_hready  = hready;
    a_err_clr = err_clr;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst_n      = 1'b0;

    a_payload_in = '0;
    a_payload_in[0*PW +: PW] = 34'h1_0000_00A0;
    a_payload_in[1*PW +: PW] = 34'h0_1234_5678;
    a_payload_in[2*PW +: PW] = 34'h2_0000_00C2;
    a_payload_in[3*PW +: PW] = 34'h3_0000_00D3;
    for (int i = 0; i < A_CH; i++) a_hwdata_in[i*DW +: DW] = 32'hCAFE_0000 + DW'(i);
    a_sel = '0; a_hready = 1'b1; a_err_clr = 1'b0;

    for (int i = 0; i < B_CH; i++) begin
      b_payload_in[i*PW +: PW] = PW'(i);
      b_hwdata_in[i*DW +: DW]  = 32'hB000_0000 + DW'(i);
    end
    b_payload_in[15*PW +: PW] = 34'h3_DEAD_BEEF;
    b_sel = '0; b_hready = 1'b1; b_err_clr = 1'b0;

    // Reset state
    #2;
    checkOutput("rst_dphase", 64'(a_dphase_sel), 64'h0);
    checkOutput("rst_addr_sel", 64'(a_addr_sel), 64'h0);
    checkOutput("rst_payload", 64'(a_payload_out), 64'h0);
    checkOutput("rst_hwdata", 64'(a_hwdata_out), 64'h0);
    checkOutput("rst_sel_err", 64'(a_sel_err), 64'h0);
    checkOutput("rst_viol", 64'(a_viol_cnt), 64'h0);
    tick;
    tick;
    rst_n = 1'b1;

    // Single granted transfer
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("t1_payload", 64'(a_payload_out), 64'h0_1234_5678);
    checkOutput("t1_addr_sel", 64'(a_addr_sel), 64'h2);
    tick;
    checkOutput("t1_dphase", 64'(a_dphase_sel), 64'h2);
    checkOutput("t1_hwdata", 64'(a_hwdata_out), 64'hCAFE_0001);

    // Stall with arbiter re-grant
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("t2_payload_pre", 64'(a_payload_out), 64'h1_0000_00A0);
    tick;
    checkOutput("t2_dphase_hold", 64'(a_dphase_sel), 64'h2);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("t2_addr_held1", 64'(a_addr_sel), 64'h1);
    checkOutput("t2_payload_held", 64'(a_payload_out), 64'h1_0000_00A0);
    tick;
    checkOutput("t2_viol1", 64'(a_viol_cnt), 64'h1);
    tick;
    checkOutput("t2_viol2", 64'(a_viol_cnt), 64'h2);
    checkOutput("t2_addr_held3", 64'(a_addr_sel), 64'h1);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    tick;
    checkOutput("t2_dphase_rel", 64'(a_dphase_sel), 64'h1);
    checkOutput("t2_hwdata_rel", 64'(a_hwdata_out), 64'hCAFE_0000);
    checkOutput("t2_addr_rel", 64'(a_addr_sel), 64'h4);
    checkOutput("t2_payload_rel", 64'(a_payload_out), 64'h2_0000_00C2);

    // Multi-hot grant and sticky error
    applyStimulus(4'b0110, 1'b1, 1'b0);
    checkOutput("t3_payload_mh", 64'(a_payload_out), 64'h0);
    checkOutput("t3_addr_mh", 64'(a_addr_sel), 64'h0);
    tick;
    checkOutput("t3_sel_err", 64'(a_sel_err), 64'h1);
    checkOutput("t3_dphase_mh", 64'(a_dphase_sel), 64'h0);
    checkOutput("t3_hwdata_mh", 64'(a_hwdata_out), 64'h0);
    applyStimulus(4'b1000, 1'b1, 1'b0);
    tick;
    checkOutput("t3_sel_err_sticky", 64'(a_sel_err), 64'h1);
    checkOutput("t3_dphase_ch3", 64'(a_dphase_sel), 64'h8);
    applyStimulus(4'b1000, 1'b1, 1'b1);
    tick;
    checkOutput("t3_clr_sel_err", 64'(a_sel_err), 64'h0);
    checkOutput("t3_clr_viol", 64'(a_viol_cnt), 64'h0);
    checkOutput("t3_clr_dphase", 64'(a_dphase_sel), 64'h8);

    // Clear beats a coincident multi-hot event
    applyStimulus(4'b0011, 1'b1, 1'b1);
    tick;
    checkOutput("t3_clr_wins", 64'(a_sel_err), 64'h0);
    applyStimulus(4'b0101, 1'b1, 1'b0);
    tick;
    checkOutput("t3_sel_err_again", 64'(a_sel_err), 64'h1);

    // Asynchronous reset in the middle of a stall
    applyStimulus(4'b1000, 1'b1, 1'b0);
    tick;
    applyStimulus(4'b1000, 1'b0, 1'b0);
    tick;
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("t5_addr_held", 64'(a_addr_sel), 64'h8);
    tick;
    checkOutput("t5_viol_pre", 64'(a_viol_cnt), 64'h1);
    checkOutput("t5_dphase_pre", 64'(a_dphase_sel), 64'h8);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_dphase", 64'(a_dphase_sel), 64'h0);
    checkOutput("t5_rst_hwdata", 64'(a_hwdata_out), 64'h0);
    checkOutput("t5_rst_hold", 64'(a_addr_sel), 64'h1);
    checkOutput("t5_rst_viol", 64'(a_viol_cnt), 64'h0);
    checkOutput("t5_rst_sel_err", 64'(a_sel_err), 64'h0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t5_rst_payload", 64'(a_payload_out), 64'h0);
    tick;
    rst_n = 1'b1;

    // Idle after reset, then a fresh grant
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t6_idle_payload", 64'(a_payload_out), 64'h0);
    tick;
    checkOutput("t6_idle_dphase", 64'(a_dphase_sel), 64'h0);
    checkOutput("t6_idle_hwdata", 64'(a_hwdata_out), 64'h0);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    tick;
    checkOutput("t6_new_dphase", 64'(a_dphase_sel), 64'h2);

    // 16 channels: top channel routing
    b_sel = 16'h8000;
    b_hready = 1'b1;
    #1;
    checkOutput("t6_ch15_payload", 64'(b_payload_out), 64'h3_DEAD_BEEF);
    tick;
    checkOutput("t6_ch15_dphase", 64'(b_dphase_sel), 64'h8000);
    checkOutput("t6_ch15_hwdata", 64'(b_hwdata_out), 64'hB000_000F);

    // 2-bit counter saturation over 5 stalled grant changes
    b_sel = 16'h0001;
    b_hready = 1'b0;
    tick;
    b_sel = 16'h0002;
    #1;
    checkOutput("t4_addr_held", 64'(b_addr_sel), 64'h1);
    for (int i = 0; i < 3; i++) tick;
    checkOutput("t4_viol_3", 64'(b_viol_cnt), 64'h3);
    tick;
    tick;
    checkOutput("t4_viol_sat", 64'(b_viol_cnt), 64'h3);
    checkOutput("t4_payload_held", 64'(b_payload_out), 64'h0);
    b_hready = 1'b1;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
